// File: rtl/lin_frame_scheduler.sv
// =============================================================================
// Module   : lin_frame_scheduler
// Brief    : LIN master frame sequencer. It generates the break and delimiter,
//            then sends sync, PID, fetched payload bytes and the checksum.
//            Optional macro LIN_PL_TIMEOUT_EN aborts a frame on a payload-ack timeout.
// Revision : 1.0
// =============================================================================
`default_nettype none

module lin_frame_scheduler #(
    parameter int SLOTS      = 4,
    parameter int BIT_CYCLES = 16,
    parameter int BREAK_BITS = 13,
    parameter int PL_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     tick,
    input  logic                     cfg_we,
    input  logic [$clog2(SLOTS)-1:0] cfg_slot,
    input  logic [31:0]              cfg_wdata,
    output logic                     break_o,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     pl_req,
    output logic [$clog2(SLOTS)-1:0] pl_slot,
    output logic [2:0]               pl_idx,
    input  logic                     pl_ack,
    input  logic [7:0]               pl_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(SLOTS)-1:0] done_slot,
    output logic                     frame_err
);

    localparam int SW      = $clog2(SLOTS);
    localparam int BRK_CYC = BREAK_BITS * BIT_CYCLES;
    localparam int TW      = (BRK_CYC > 1) ? $clog2(BRK_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_BREAK = 4'd1,
        S_DELIM = 4'd2,
        S_SYNC  = 4'd3,
        S_PID   = 4'd4,
        S_FETCH = 4'd5,
        S_DATA  = 4'd6,
        S_CKSUM = 4'd7,
        S_DONE  = 4'd8,
        S_WAIT  = 4'd9
    } state_t;

    // Schedule table
    logic [5:0]  tbl_id_q  [SLOTS];
    logic [3:0]  tbl_len_q [SLOTS];
    logic        tbl_enh_q [SLOTS];
    logic [15:0] tbl_per_q [SLOTS];

    state_t          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [5:0]      id_q, id_d;
    logic [3:0]      len_q, len_d;
    logic            enh_q, enh_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      sum_q, sum_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [15:0]     wait_q, wait_d;

    logic            w_sel_found;
    logic [SW-1:0]   w_sel_slot;
    logic [SW-1:0]   w_cand;
    logic [3:0]      w_sel_len;
    logic [7:0]      w_pid;
    logic            w_unused;

`ifdef LIN_PL_TIMEOUT_EN
    localparam int TOW = (PL_TIMEOUT > 1) ? $clog2(PL_TIMEOUT) : 1;
    logic [TOW-1:0]  to_q, to_d;
    logic            ferr_q, ferr_d;
`endif

    function automatic logic [7:0] cks_add(input logic [7:0] s, input logic [7:0] b);
        logic [8:0] t;
        t = {1'b0, s} + {1'b0, b};
        return t[7:0] + {7'd0, t[8]};
    endfunction

    function automatic logic [7:0] pid_of(input logic [5:0] id);
        logic p0;
        logic p1;
        p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
        p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
        return {p1, p0, id};
    endfunction

    assign w_pid = pid_of(id_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                tbl_id_q[i]  <= '0;
                tbl_len_q[i] <= '0;
                tbl_enh_q[i] <= 1'b0;
                tbl_per_q[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl_id_q[cfg_slot]  <= cfg_wdata[5:0];
            tbl_len_q[cfg_slot] <= cfg_wdata[9:6];
            tbl_enh_q[cfg_slot] <= cfg_wdata[10];
            tbl_per_q[cfg_slot] <= cfg_wdata[31:16];
        end
    end

    // Round-robin pick: lowest offset from the pointer wins, hence the reverse scan.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_slot  = ptr_q;
        w_cand      = ptr_q;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            w_cand = ptr_q + SW'(k);
            if (tbl_per_q[w_cand] != 16'd0) begin
                w_sel_found = 1'b1;
                w_sel_slot  = w_cand;
            end
        end
    end

    assign w_sel_len = (tbl_len_q[w_sel_slot] > 4'd8) ? 4'd8 : tbl_len_q[w_sel_slot];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            slot_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            enh_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            tmr_q   <= '0;
            wait_q  <= '0;
`ifdef LIN_PL_TIMEOUT_EN
            to_q    <= '0;
            ferr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            slot_q  <= slot_d;
            id_q    <= id_d;
            len_q   <= len_d;
            enh_q   <= enh_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            tmr_q   <= tmr_d;
            wait_q  <= wait_d;
`ifdef LIN_PL_TIMEOUT_EN
            to_q    <= to_d;
            ferr_q  <= ferr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        slot_d   = slot_q;
        id_d     = id_q;
        len_d    = len_q;
        enh_d    = enh_q;
        idx_d    = idx_q;
        data_d   = data_q;
        sum_d    = sum_q;
        tmr_d    = tmr_q;
        wait_d   = wait_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
`ifdef LIN_PL_TIMEOUT_EN
        to_d     = (state_q == S_FETCH) ? to_q + TOW'(1) : '0;
        ferr_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable && w_sel_found) begin
                    state_d = S_BREAK;
                    slot_d  = w_sel_slot;
                    id_d    = tbl_id_q[w_sel_slot];
                    len_d   = w_sel_len;
                    enh_d   = tbl_enh_q[w_sel_slot];
                    idx_d   = '0;
                    sum_d   = '0;
                    tmr_d   = TW'(BRK_CYC - 1);
                end
            end
            S_BREAK: begin
                if (tmr_q == '0) begin
                    state_d = S_DELIM;
                    tmr_d   = TW'(BIT_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DELIM: begin
                if (tmr_q == '0) begin
                    state_d = S_SYNC;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = 8'h55;
                if (tx_ready) begin
                    state_d = S_PID;
                end
            end
            S_PID: begin
                tx_valid = 1'b1;
                tx_data  = w_pid;
                if (tx_ready) begin
                    if (enh_q) begin
                        sum_d = w_pid;
                    end
                    state_d = (len_q == 4'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (pl_ack) begin
                    data_d  = pl_data;
                    state_d = S_DATA;
                end
`ifdef LIN_PL_TIMEOUT_EN
                else if (to_q == TOW'(PL_TIMEOUT - 1)) begin
                    state_d = S_WAIT;
                    wait_d  = tbl_per_q[slot_q];
                    ptr_d   = slot_q + SW'(1);
                    ferr_d  = 1'b1;
                end
`endif
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = data_q;
                if (tx_ready) begin
                    sum_d   = cks_add(sum_q, data_q);
                    idx_d   = idx_q + 4'd1;
                    state_d = (idx_q + 4'd1 == len_q) ? S_CKSUM : S_FETCH;
                end
            end
            S_CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = ~sum_q;
                if (tx_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wait_d  = tbl_per_q[slot_q];
                ptr_d   = slot_q + SW'(1);
                // Dropping enable parks the scheduler without running the period countdown.
                state_d = enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (wait_q == 16'd0) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    wait_d = wait_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign break_o    = (state_q == S_BREAK);
    assign busy       = (state_q == S_BREAK) || (state_q == S_DELIM) || (state_q == S_SYNC) ||
                        (state_q == S_PID)   || (state_q == S_FETCH) || (state_q == S_DATA) ||
                        (state_q == S_CKSUM);
    assign pl_req     = (state_q == S_FETCH);
    assign pl_slot    = pl_req ? slot_q : '0;
    assign pl_idx     = pl_req ? idx_q[2:0] : 3'd0;
    assign frame_done = (state_q == S_DONE);
    assign done_slot  = frame_done ? slot_q : '0;

`ifdef LIN_PL_TIMEOUT_EN
    assign frame_err = ferr_q;
    assign w_unused  = ^cfg_wdata[15:11];
`else
    assign frame_err = 1'b0;
    assign w_unused  = (^cfg_wdata[15:11]) ^ (PL_TIMEOUT != 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_lin_frame_scheduler.sv
// =============================================================================
// Module   : tb_lin_frame_scheduler
// Brief    : Directed self-checking bench for lin_frame_scheduler.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_lin_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tick;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic [31:0] cfg_wdata;
    logic        break_o;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        pl_req;
    logic [1:0]  pl_slot;
    logic [2:0]  pl_idx;
    logic        pl_ack;
    logic [7:0]  pl_data;
    logic        busy;
    logic        frame_done;
    logic [1:0]  done_slot;
    logic        frame_err;

    lin_frame_scheduler #(
        .SLOTS(4), .BIT_CYCLES(16), .BREAK_BITS(13), .PL_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_wdata(cfg_wdata),
        .break_o(break_o), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .pl_req(pl_req), .pl_slot(pl_slot), .pl_idx(pl_idx), .pl_ack(pl_ack), .pl_data(pl_data),
        .busy(busy), .frame_done(frame_done), .done_slot(done_slot), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pay [0:3][0:7];
    logic       ack_en;
    logic [7:0] txq [$];
    logic [1:0] doneq [$];
    int         done_cnt, preq_cycles, ferr_cnt;
    int         brk_run, brk_len, delim_run, delim_len;
    bit         in_delim;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload responder and bus monitor, both evaluated on the falling edge.
    initial begin
        pl_ack  = 1'b0;
        pl_data = 8'h00;
        forever begin
            @(negedge clk);
            pl_ack  = pl_req && ack_en;
            pl_data = pay[pl_slot][pl_idx];
        end
    end

    initial begin
        done_cnt = 0; preq_cycles = 0; ferr_cnt = 0;
        brk_run = 0; brk_len = 0; delim_run = 0; delim_len = 0; in_delim = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                brk_run  = 0;
                in_delim = 1'b0;
            end else if (break_o) begin
                brk_run++;
                in_delim = 1'b0;
            end else begin
                if (brk_run != 0) begin
                    brk_len   = brk_run;
                    brk_run   = 0;
                    in_delim  = 1'b1;
                    delim_run = 0;
                end
                if (in_delim) begin
                    if (tx_valid) begin
                        delim_len = delim_run;
                        in_delim  = 1'b0;
                    end else begin
                        delim_run++;
                    end
                end
            end
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            if (frame_done) begin
                doneq.push_back(done_slot);
                done_cnt++;
            end
            if (pl_req) preq_cycles++;
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; tick = 1'b0; cfg_we = 1'b0;
        cfg_slot = '0; cfg_wdata = '0; tx_ready = 1'b1; ack_en = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [5:0] id, input logic [3:0] len,
                             input logic enh, input logic [15:0] per);
        cfg_we    = 1'b1;
        cfg_slot  = s;
        cfg_wdata = {per, 5'd0, enh, len, id};
        step(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(done_cnt != start), 32'd1);
    endtask

    function automatic logic [7:0] byte_at(input int i);
        if (i < txq.size()) return txq[i];
        return 8'hxx;
    endfunction

    initial begin
        int ok;
        int n;
        int d0;
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 8; j++)
                pay[s][j] = 8'(s * 16 + j);
        pay[0][0] = 8'h55;
        pay[0][1] = 8'hAA;
        pay[2][0] = 8'h12;

        // Reset state
        rst = 1'b1; enable = 1'b0; tick = 1'b0; cfg_we = 1'b0;
        cfg_slot = '0; cfg_wdata = '0; tx_ready = 1'b1; ack_en = 1'b1;
        step(2);
        check("rst_ctrl", {26'd0, break_o, tx_valid, busy, pl_req, frame_done, frame_err}, 32'd0);
        check("rst_data", {19'd0, tx_data, pl_idx, done_slot}, 32'd0);
        rst = 1'b0;
        step(1);

        // Classic frame on slot 0
        cfg_write(2'd0, 6'h3C, 4'd2, 1'b0, 16'd1);
        txq.delete(); doneq.delete();
        enable = 1'b1;
        wait_done("t1_done", 1000);
        check("t1_break_len", brk_len, 32'd208);
        check("t1_delim_len", delim_len, 32'd16);
        check("t1_nbytes", txq.size(), 32'd5);
        check("t1_b0", byte_at(0), 32'h55);
        check("t1_b1", byte_at(1), 32'h3C);
        check("t1_b2", byte_at(2), 32'h55);
        check("t1_b3", byte_at(3), 32'hAA);
        check("t1_cksum", byte_at(4), 32'h00);
        check("t1_slot", (doneq.size() > 0) ? 32'(doneq[0]) : 32'hFF, 32'd0);
        enable = 1'b0;
        pulse_tick();

        // Enhanced checksum includes the PID and needs an end-around carry
        cfg_write(2'd0, 6'h3C, 4'd2, 1'b1, 16'd1);
        txq.delete();
        enable = 1'b1;
        wait_done("t2_done", 1000);
        check("t2_nbytes", txq.size(), 32'd5);
        check("t2_cksum", byte_at(4), 32'hC3);
        enable = 1'b0;
        pulse_tick();

        // Enable dropped mid-frame: frame completes, then parks without waiting for tick
        txq.delete();
        enable = 1'b1;
        step(20);
        check("t3_busy_mid", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_done("t3_done", 1000);
        check("t3_nbytes", txq.size(), 32'd5);
        step(5);
        check("t3_parked", {30'd0, busy, break_o}, 32'd0);
        enable = 1'b1;
        step(3);
        check("t3_restart", 32'(break_o), 32'd1);
        enable = 1'b0;
        wait_done("t3_done2", 1000);

        // Header-only frame on slot 1, period 2
        cfg_write(2'd0, 6'h00, 4'd0, 1'b0, 16'd0);
        cfg_write(2'd1, 6'h01, 4'd0, 1'b0, 16'd2);
        txq.delete(); doneq.delete();
        preq_cycles = 0;
        enable = 1'b1;
        wait_done("t4_done", 1000);
        check("t4_nbytes", txq.size(), 32'd2);
        check("t4_b0", byte_at(0), 32'h55);
        check("t4_pid", byte_at(1), 32'hC1);
        check("t4_no_req", preq_cycles, 32'd0);
        check("t4_slot", (doneq.size() > 0) ? 32'(doneq[0]) : 32'hFF, 32'd1);
        step(5);
        check("t4_wait0", 32'(busy), 32'd0);
        pulse_tick();
        step(5);
        check("t4_wait1", 32'(busy), 32'd0);
        pulse_tick();
        step(3);
        check("t4_wait2", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_done("t4_done2", 1000);

        // Round-robin skips the disabled slot 1
        do_reset();
        cfg_write(2'd0, 6'h3C, 4'd2, 1'b0, 16'd1);
        cfg_write(2'd2, 6'h10, 4'd1, 1'b0, 16'd1);
        txq.delete(); doneq.delete();
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_done("t5_done", 1000);
            if (f == 3) enable = 1'b0;
            pulse_tick();
        end
        check("t5_nframes", doneq.size(), 32'd4);
        for (int f = 0; f < 4; f++)
            check("t5_order", (f < doneq.size()) ? 32'(doneq[f]) : 32'hFF, (f % 2 == 0) ? 32'd0 : 32'd2);
        check("t5_pid2", byte_at(6), 32'h50);
        check("t5_data2", byte_at(7), 32'h12);
        check("t5_cksum2", byte_at(8), 32'hED);

        // tx_ready stall during PID, then async reset mid-break
        do_reset();
        cfg_write(2'd1, 6'h01, 4'd0, 1'b0, 16'd1);
        txq.delete();
        enable = 1'b1;
        n = 0;
        while (!tx_valid && n < 500) begin
            step(1);
            n++;
        end
        check("t6_sync_seen", 32'(tx_valid), 32'd1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid === 1'b1 && tx_data === 8'hC1) ok++;
            step(1);
        end
        check("t6_stall_hold", ok, 32'd10);
        tx_ready = 1'b1;
        wait_done("t6_done", 100);
        check("t6_nbytes", txq.size(), 32'd2);
        check("t6_pid", byte_at(1), 32'hC1);
        pulse_tick();
        step(10);
        check("t6_in_break", {30'd0, break_o, busy}, 32'd3);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_rst", {28'd0, break_o, tx_valid, busy, pl_req}, 32'd0);
        step(2);
        rst = 1'b0;
        enable = 1'b0;
        step(1);

`ifdef LIN_PL_TIMEOUT_EN
        // Payload never acknowledged: abort with frame_err, then continue with slot 1
        do_reset();
        cfg_write(2'd0, 6'h3C, 4'd2, 1'b0, 16'd1);
        cfg_write(2'd1, 6'h01, 4'd0, 1'b0, 16'd1);
        txq.delete(); doneq.delete();
        ack_en = 1'b0;
        preq_cycles = 0;
        ferr_cnt = 0;
        d0 = done_cnt;
        enable = 1'b1;
        n = 0;
        while (ferr_cnt == 0 && n < 1000) begin
            step(1);
            n++;
        end
        check("t7_err_seen", ferr_cnt, 32'd1);
        check("t7_req_cycles", preq_cycles, 32'd64);
        check("t7_no_cksum", txq.size(), 32'd2);
        check("t7_no_done", done_cnt - d0, 32'd0);
        ack_en = 1'b1;
        pulse_tick();
        wait_done("t7_next_done", 1000);
        check("t7_next_slot", (doneq.size() > 0) ? 32'(doneq[0]) : 32'hFF, 32'd1);
        enable = 1'b0;
`else
        d0 = 0;
        check("no_frame_err", ferr_cnt, 32'(d0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
